// File: rtl/bsg_manycore_link_fifo_serdes.sv
// bsg_manycore_link_fifo_serdes
//
// Bridges manycore request packets and a narrower host FIFO link.
//   - Serializer: takes one packet on pkt_i/pkt_v_i (yumi handshake) and emits
//     it as beats_lp beats on fifo_data_o/fifo_v_o, LSB beat first. The last
//     beat is zero-padded above packet_width_p.
//   - Deserializer: collects beats_lp beats from fifo_data_i/fifo_v_i and
//     presents the packet on pkt_o/pkt_v_o until pkt_ready_i. A held packet can
//     drain in the same cycle that the first beat of the next one arrives.
//   - Optional credit counter bounds the number of outstanding host-bound
//     packets. It is compiled in only when BSG_MANYCORE_LINK_FIFO_SERDES_CREDIT_EN
//     is defined. Otherwise credits_o reads max_out_credits_p and
//     credit_return_v_i is ignored.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   pkt_i/pkt_v_i           packet in, pkt_yumi_o consumes it
//   fifo_data_o/fifo_v_o    outgoing beat, fifo_ready_i accepts it
//   fifo_data_i/fifo_v_i    incoming beat, fifo_ready_o accepts it
//   pkt_o/pkt_v_o           reassembled packet, pkt_ready_i accepts it
//   credit_return_v_i       host returns one credit
//   credits_o               registered available credit count
//
// Serializer states
//   state | meaning
//   IDLE  | no packet held, may consume pkt_i
//   SEND  | packet held, presenting beat idx_q on the link
//
// packet_width_p has no meaningful default; instantiators always set it.

module bsg_manycore_link_fifo_serdes #(
   parameter int packet_width_p    = 100,
   parameter int fifo_width_p      = 32,
   parameter int max_out_credits_p = 16,
   localparam int beats_lp         = (packet_width_p + fifo_width_p - 1) / fifo_width_p,
   localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,

   input  logic [packet_width_p-1:0]  pkt_i,
   input  logic                       pkt_v_i,
   output logic                       pkt_yumi_o,

   output logic [fifo_width_p-1:0]    fifo_data_o,
   output logic                       fifo_v_o,
   input  logic                       fifo_ready_i,

   input  logic [fifo_width_p-1:0]    fifo_data_i,
   input  logic                       fifo_v_i,
   output logic                       fifo_ready_o,

   output logic [packet_width_p-1:0]  pkt_o,
   output logic                       pkt_v_o,
   input  logic                       pkt_ready_i,

   input  logic                       credit_return_v_i,
   output logic [credit_width_lp-1:0] credits_o
);

   localparam int pad_width_lp = beats_lp * fifo_width_p;
   localparam int idx_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
   localparam int cnt_width_lp = $clog2(beats_lp + 1);

   // Low until the first clock edge after reset release; keeps both ready and
   // yumi deasserted while in reset and on the release cycle itself.
   logic alive_q;
   logic credit_avail;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) alive_q <= 1'b0;
      else            alive_q <= 1'b1;
   end

   // ---------------------------------------------------------------- serializer
   typedef enum logic {SER_IDLE, SER_SEND} ser_state_e;

   ser_state_e                ser_state_q, ser_state_d;
   logic [idx_width_lp-1:0]   idx_q, idx_d;
   logic [packet_width_p-1:0] ser_pkt_q, ser_pkt_d;
   logic [pad_width_lp-1:0]   ser_pkt_pad;

   assign ser_pkt_pad = pad_width_lp'(ser_pkt_q);
   assign fifo_data_o = ser_pkt_pad[int'(idx_q) * fifo_width_p +: fifo_width_p];

   always_comb begin
      ser_state_d = ser_state_q;
      idx_d       = idx_q;
      ser_pkt_d   = ser_pkt_q;
      pkt_yumi_o  = 1'b0;
      fifo_v_o    = 1'b0;
      unique case (ser_state_q)
         SER_IDLE: begin
            pkt_yumi_o = alive_q & pkt_v_i & credit_avail;
            if (pkt_yumi_o) begin
               ser_pkt_d   = pkt_i;
               idx_d       = '0;
               ser_state_d = SER_SEND;
            end
         end
         SER_SEND: begin
            fifo_v_o = 1'b1;
            if (fifo_ready_i) begin
               if (idx_q == idx_width_lp'(beats_lp - 1)) ser_state_d = SER_IDLE;
               else                                       idx_d       = idx_q + 1'b1;
            end
         end
         default: ser_state_d = SER_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ser_state_q <= SER_IDLE;
         idx_q       <= '0;
      end else begin
         ser_state_q <= ser_state_d;
         idx_q       <= idx_d;
      end
   end

   always_ff @(posedge clk_i) begin
      ser_pkt_q <= ser_pkt_d;
   end

   // -------------------------------------------------------------- deserializer
   logic [cnt_width_lp-1:0]   rx_cnt_q, rx_cnt_d;
   logic [packet_width_p-1:0] rx_pkt_q;
   wire  [packet_width_p-1:0] rx_pkt_d;
   logic                      rx_full, rx_drain, rx_accept;
   logic [cnt_width_lp-1:0]   rx_slot;

   assign rx_full      = (rx_cnt_q == cnt_width_lp'(beats_lp));
   assign rx_drain     = rx_full & pkt_ready_i;
   assign fifo_ready_o = alive_q & (~rx_full | pkt_ready_i);
   assign rx_accept    = fifo_v_i & fifo_ready_o;
   // A beat arriving while the held packet drains is the first beat of the next.
   assign rx_slot      = rx_drain ? '0 : rx_cnt_q;

   assign pkt_v_o = rx_full;
   assign pkt_o   = rx_pkt_q;

   // Each slot only keeps the bits that land inside packet_width_p; the upper
   // bits of the last beat are dropped here.
   for (genvar b = 0; b < beats_lp; b++) begin : g_slot
      localparam int lo_lp = b * fifo_width_p;
      localparam int w_lp  = (packet_width_p - lo_lp < fifo_width_p) ?
                             (packet_width_p - lo_lp) : fifo_width_p;
      assign rx_pkt_d[lo_lp +: w_lp] =
         (rx_accept && (rx_slot == cnt_width_lp'(b))) ? fifo_data_i[w_lp-1:0]
                                                      : rx_pkt_q[lo_lp +: w_lp];
   end

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      if (rx_drain)       rx_cnt_d = rx_accept ? cnt_width_lp'(1) : '0;
      else if (rx_accept) rx_cnt_d = rx_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rx_cnt_q <= '0;
      else            rx_cnt_q <= rx_cnt_d;
   end

   always_ff @(posedge clk_i) begin
      rx_pkt_q <= rx_pkt_d;
   end

   // ------------------------------------------------------------------- credits
`ifdef BSG_MANYCORE_LINK_FIFO_SERDES_CREDIT_EN
   logic [credit_width_lp-1:0] credits_q, credits_d;

   always_comb begin
      credits_d = credits_q;
      if (pkt_yumi_o && !credit_return_v_i)
         credits_d = credits_q - 1'b1;
      else if (!pkt_yumi_o && credit_return_v_i &&
               (credits_q != credit_width_lp'(max_out_credits_p)))
         credits_d = credits_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) credits_q <= credit_width_lp'(max_out_credits_p);
      else            credits_q <= credits_d;
   end

   assign credit_avail = (credits_q != '0);
   assign credits_o    = credits_q;

   // A return with every credit already home is a host protocol bug; the
   // counter saturates and simulation flags it.
   credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(credit_return_v_i && !pkt_yumi_o &&
        (credits_q == credit_width_lp'(max_out_credits_p))));
`else
   wire unused_credit_return = credit_return_v_i;

   assign credit_avail = 1'b1;
   assign credits_o    = credit_width_lp'(max_out_credits_p);
`endif

endmodule

// File: tb/tb_bsg_manycore_link_fifo_serdes.sv
// Bench for bsg_manycore_link_fifo_serdes with packet 100 b, fifo 32 b, 2 credits.
// A queue-level model runs beside the DUT and is compared every cycle. Directed
// sequences add literal expectations. Works with and without
// BSG_MANYCORE_LINK_FIFO_SERDES_CREDIT_EN.

module tb_bsg_manycore_link_fifo_serdes;

   localparam int PW = 100;
   localparam int FW = 32;
   localparam int MC = 2;
   localparam int BEATS = 4;
   localparam int CW = 2;
`ifdef BSG_MANYCORE_LINK_FIFO_SERDES_CREDIT_EN
   localparam bit CRED_EN = 1'b1;
`else
   localparam bit CRED_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic [PW-1:0] pkt_i;
   logic          pkt_v_i;
   logic          pkt_yumi_o;
   logic [FW-1:0] fifo_data_o;
   logic          fifo_v_o;
   logic          fifo_ready_i;
   logic [FW-1:0] fifo_data_i;
   logic          fifo_v_i;
   logic          fifo_ready_o;
   logic [PW-1:0] pkt_o;
   logic          pkt_v_o;
   logic          pkt_ready_i;
   logic          credit_return_v_i;
   logic [CW-1:0] credits_o;

   // directed drives and loopback mux
   logic          loop_mode;
   logic          tb_fifo_ready, tb_fifo_v, tb_pkt_ready, tb_ret;
   logic [FW-1:0] tb_fifo_data;
   logic          lb_en, lb_pr;

   assign fifo_v_i          = loop_mode ? (fifo_v_o & lb_en)     : tb_fifo_v;
   assign fifo_data_i       = loop_mode ? fifo_data_o            : tb_fifo_data;
   assign fifo_ready_i      = loop_mode ? (fifo_ready_o & lb_en) : tb_fifo_ready;
   assign pkt_ready_i       = loop_mode ? lb_pr                  : tb_pkt_ready;
   assign credit_return_v_i = loop_mode ? (pkt_v_o & pkt_ready_i) : tb_ret;

   bsg_manycore_link_fifo_serdes #(
      .packet_width_p(PW), .fifo_width_p(FW), .max_out_credits_p(MC)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .pkt_i(pkt_i), .pkt_v_i(pkt_v_i), .pkt_yumi_o(pkt_yumi_o),
      .fifo_data_o(fifo_data_o), .fifo_v_o(fifo_v_o), .fifo_ready_i(fifo_ready_i),
      .fifo_data_i(fifo_data_i), .fifo_v_i(fifo_v_i), .fifo_ready_o(fifo_ready_o),
      .pkt_o(pkt_o), .pkt_v_o(pkt_v_o), .pkt_ready_i(pkt_ready_i),
      .credit_return_v_i(credit_return_v_i), .credits_o(credits_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] beat_of(input logic [PW-1:0] p, input int i);
      logic [127:0] t;
      t = 128'(p);
      return t[i*FW +: FW];
   endfunction

   // ------------------------------------------------------------------ model
   logic [FW-1:0] m_tx_q[$];
   logic [FW-1:0] m_rx_q[$];
   bit            m_alive;
   int            m_credits;

   always @(negedge clk_i) begin
      bit exp_tx_v, exp_yumi, exp_full, exp_fready;
      logic [127:0] acc;
      if (!reset_n_i) begin
         m_tx_q.delete();
         m_rx_q.delete();
         m_alive   = 0;
         m_credits = MC;
         check("rst_fifo_v", fifo_v_o, 0);
         check("rst_pkt_v", pkt_v_o, 0);
         check("rst_yumi", pkt_yumi_o, 0);
         check("rst_fifo_ready", fifo_ready_o, 0);
         check("rst_credits", credits_o, MC);
      end else begin
         exp_tx_v   = (m_tx_q.size() != 0);
         exp_yumi   = m_alive && !exp_tx_v && (pkt_v_i === 1'b1) && (m_credits != 0);
         exp_full   = (m_rx_q.size() == BEATS);
         exp_fready = m_alive && (!exp_full || (pkt_ready_i === 1'b1));
         check("fifo_v", fifo_v_o, exp_tx_v);
         check("yumi", pkt_yumi_o, exp_yumi);
         check("pkt_v", pkt_v_o, exp_full);
         check("fifo_ready", fifo_ready_o, exp_fready);
         check("credits", credits_o, m_credits);
         if (exp_tx_v) check("fifo_data", fifo_data_o, m_tx_q[0]);
         if (exp_full) begin
            acc = '0;
            for (int i = 0; i < BEATS; i++) acc[i*FW +: FW] = m_rx_q[i];
            check("pkt_o", pkt_o, 128'(acc[PW-1:0]));
         end
         if (exp_tx_v && fifo_ready_i) void'(m_tx_q.pop_front());
         if (exp_yumi)
            for (int i = 0; i < BEATS; i++) m_tx_q.push_back(beat_of(pkt_i, i));
         if (CRED_EN) begin
            if (exp_yumi && !credit_return_v_i) m_credits--;
            else if (!exp_yumi && credit_return_v_i && m_credits < MC) m_credits++;
         end
         if (exp_full && pkt_ready_i) m_rx_q.delete();
         if (fifo_v_i && exp_fready) m_rx_q.push_back(fifo_data_i);
         m_alive = 1;
      end
   end

   // -------------------------------------------------- observation / scoreboard
   int            yumi_cnt = 0;
   int            rx_cnt   = 0;
   logic [FW-1:0] beats_seen[$];
   logic [PW-1:0] sent_q[$];

   always @(negedge clk_i) begin
      logic [PW-1:0] e;
      if (reset_n_i) begin
         if (pkt_yumi_o) begin
            yumi_cnt++;
            if (loop_mode) sent_q.push_back(pkt_i);
         end
         if (fifo_v_o && fifo_ready_i) beats_seen.push_back(fifo_data_o);
         if (loop_mode && pkt_v_o && pkt_ready_i) begin
            rx_cnt++;
            if (sent_q.size() == 0) check("loop_extra_pkt", 1, 0);
            else begin
               e = sent_q.pop_front();
               check("loop_pkt", pkt_o, e);
            end
         end
      end
   end

   always @(posedge clk_i) begin
      #1;
      lb_en = 1'($urandom_range(0, 1));
      lb_pr = 1'($urandom_range(0, 1));
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic offer_pkt(input logic [PW-1:0] p, input int limit);
      bit got;
      got     = 0;
      pkt_i   = p;
      pkt_v_i = 1'b1;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk_i);
         if (pkt_yumi_o === 1'b1) begin
            got = 1;
            break;
         end
      end
      @(posedge clk_i);
      #1;
      pkt_v_i = 1'b0;
      check("offer_yumi", got, 1);
   endtask

   task automatic wait_beats(input int n);
      for (int k = 0; k < 50; k++) begin
         if (beats_seen.size() >= n) break;
         tick();
      end
      check("beat_count", beats_seen.size(), n);
   endtask

   task automatic rx_beat(input logic [FW-1:0] d);
      tb_fifo_v    = 1'b1;
      tb_fifo_data = d;
      tick();
      tb_fifo_v    = 1'b0;
   endtask

   task automatic return_credit();
      tb_ret = 1'b1;
      tick();
      tb_ret = 1'b0;
   endtask

   initial begin
      logic [PW-1:0] pa, pq, r;
      logic [127:0]  rnd;
      int            yc;
      reset_n_i = 1'b0;
      loop_mode = 1'b0;
      pkt_i = '0; pkt_v_i = 1'b0;
      tb_fifo_ready = 1'b0; tb_fifo_v = 1'b0; tb_pkt_ready = 1'b0; tb_ret = 1'b0;
      tb_fifo_data = '0;
      lb_en = 1'b0; lb_pr = 1'b0;
      repeat (3) tick();

      // reset state with a packet on offer
      pkt_v_i = 1'b1;
      #1;
      check("reset_yumi", pkt_yumi_o, 0);
      check("reset_fifo_ready", fifo_ready_o, 0);
      check("reset_credits", credits_o, 2);
      pkt_v_i   = 1'b0;
      reset_n_i = 1'b1;
      #1;
      check("release_fifo_ready", fifo_ready_o, 0);
      tick();
      check("post_edge_fifo_ready", fifo_ready_o, 1);

      // single packet, host always ready
      pa = 100'hA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
      tb_fifo_ready = 1'b1;
      beats_seen.delete();
      yc = yumi_cnt;
      offer_pkt(pa, 20);
      wait_beats(4);
      check("beat0", beats_seen[0], 32'hDDDDDDDD);
      check("beat1", beats_seen[1], 32'hCCCCCCCC);
      check("beat2", beats_seen[2], 32'hBBBBBBBB);
      check("beat3", beats_seen[3], 32'h0000000A);
      check("one_yumi", yumi_cnt - yc, 1);
      check("credits_after_one", credits_o, CRED_EN ? 1 : 2);
      return_credit();
      check("credits_restored", credits_o, 2);

`ifdef BSG_MANYCORE_LINK_FIFO_SERDES_CREDIT_EN
      // credit exhaustion: third packet stalls until a credit returns
      beats_seen.delete();
      offer_pkt(100'h1, 20);
      wait_beats(4);
      beats_seen.delete();
      offer_pkt(100'h2, 20);
      wait_beats(4);
      check("credits_empty", credits_o, 0);
      yc = yumi_cnt;
      pkt_i   = 100'h3;
      pkt_v_i = 1'b1;
      repeat (10) tick();
      check("stall_no_yumi", yumi_cnt - yc, 0);
      tb_ret = 1'b1;
      tick();
      tb_ret = 1'b0;
      #1;
      check("yumi_after_return", pkt_yumi_o, 1);
      check("credits_after_return", credits_o, 1);
      tick();
      pkt_v_i = 1'b0;
      check("third_yumi", yumi_cnt - yc, 1);
      check("credits_empty2", credits_o, 0);
      beats_seen.delete();
      wait_beats(4);
      return_credit();
      return_credit();
      check("credits_back", credits_o, 2);

      // yumi and return in the same cycle at one credit
      beats_seen.delete();
      offer_pkt(100'h4, 20);
      wait_beats(4);
      check("credits_one", credits_o, 1);
      pkt_i   = 100'h5;
      pkt_v_i = 1'b1;
      tb_ret  = 1'b1;
      #1;
      check("simul_yumi", pkt_yumi_o, 1);
      tick();
      pkt_v_i = 1'b0;
      tb_ret  = 1'b0;
      check("simul_credits", credits_o, 1);
      beats_seen.delete();
      wait_beats(4);
      return_credit();
`else
      // without the counter packets are never throttled
      for (int i = 0; i < 3; i++) begin
         beats_seen.delete();
         offer_pkt(PW'(i + 1), 20);
         wait_beats(4);
         check("nocred_credits", credits_o, 2);
      end
`endif

      // deserializer: hold, drop upper bits, drain-and-fill
      tb_pkt_ready = 1'b0;
      rx_beat(32'h1);
      rx_beat(32'h2);
      rx_beat(32'h3);
      rx_beat(32'hFFFFFFFF);
      check("rx_full_v", pkt_v_o, 1);
      check("rx_full_pkt", pkt_o, 100'hF_00000003_00000002_00000001);
      check("rx_full_ready", fifo_ready_o, 0);
      tick();
      check("rx_hold_pkt", pkt_o, 100'hF_00000003_00000002_00000001);
      tb_fifo_v    = 1'b1;
      tb_fifo_data = 32'h55;
      tb_pkt_ready = 1'b1;
      #1;
      check("drain_fill_ready", fifo_ready_o, 1);
      tick();
      tb_fifo_v    = 1'b0;
      tb_pkt_ready = 1'b0;
      check("drain_fill_v", pkt_v_o, 0);
      rx_beat(32'h66);
      rx_beat(32'h77);
      rx_beat(32'h8);
      check("refill_v", pkt_v_o, 1);
      check("refill_pkt", pkt_o, 100'h8_00000077_00000066_00000055);
      tb_pkt_ready = 1'b1;
      tick();
      tb_pkt_ready = 1'b0;

      // reset in the middle of a packet on both paths
      beats_seen.delete();
      offer_pkt(100'h9_11111111_22222222_33333333, 20);
      rx_beat(32'hDEAD0001);
      rx_beat(32'hDEAD0002);
      reset_n_i = 1'b0;
      repeat (2) tick();
      reset_n_i = 1'b1;
      tick();
      check("pre_reset_beats", beats_seen.size(), 2);
      check("post_reset_credits", credits_o, 2);
      check("post_reset_pkt_v", pkt_v_o, 0);
      beats_seen.delete();
      pq = 100'h7_44444444_55555555_66666666;
      offer_pkt(pq, 20);
      wait_beats(4);
      check("rst_beat0", beats_seen[0], 32'h66666666);
      check("rst_beat3", beats_seen[3], 32'h00000007);
      rx_beat(32'hA1);
      rx_beat(32'hA2);
      rx_beat(32'hA3);
      check("rst_rx_partial_v", pkt_v_o, 0);
      rx_beat(32'hA4);
      check("rst_rx_pkt", pkt_o, 100'h4_000000A3_000000A2_000000A1);
      tb_pkt_ready = 1'b1;
      tick();
      tb_pkt_ready = 1'b0;
      return_credit();
      check("credits_final_directed", credits_o, 2);

      // random back-pressure loopback
      loop_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         r   = rnd[PW-1:0];
         offer_pkt(r, 400);
      end
      for (int k = 0; k < 2000; k++) begin
         if (rx_cnt >= 1000) break;
         tick();
      end
      check("loop_rx_count", rx_cnt, 1000);
      check("loop_sent_left", sent_q.size(), 0);
      loop_mode = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
